// File: rtl/frame_tx_lanes_if.sv
// Frame serializer bus: payload write port, frame request handshake and lane output.
// The slave side is the serializer; the master side is whatever feeds and observes it.
`timescale 1ns/1ps
interface frame_tx_lanes_if #(
    parameter int DATA_W = 8,
    parameter int LANE_W = 1,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 4
);
    logic              frame_en;
    logic [LEN_W-1:0]  frame_len;
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic [LANE_W-1:0] data_out;
    logic              data_out_valid;
    logic              frame_ready;
    logic              frame_done;
    logic              underrun;
    logic [ADDR_W:0]   fifo_level;

    modport slave (
        input  frame_en, frame_len, data_in, data_in_valid,
        output data_in_ready, data_out, data_out_valid, frame_ready,
               frame_done, underrun, fifo_level
    );

    modport master (
        output frame_en, frame_len, data_in, data_in_valid,
        input  data_in_ready, data_out, data_out_valid, frame_ready,
               frame_done, underrun, fifo_level
    );
endinterface

// File: rtl/frame_tx_lanes.sv
// Preamble/SFD/payload serializer with a payload FIFO, LANE_W bits per cycle, LSB first.
//
// state   | meaning
// S_IDLE  | waiting for frame_en with a non-zero length
// S_PRE   | emitting preamble lanes
// S_SFD   | emitting start-of-frame delimiter lanes
// S_PAY   | emitting payload lanes of the current word
// S_STALL | payload word needed but FIFO empty, output idle
// S_GAP   | inter-frame gap, IFG idle cycles
`timescale 1ns/1ps
module frame_tx_lanes #(
    parameter int                  DATA_W     = 8,
    parameter int                  LANE_W     = 1,
    parameter int                  FIFO_DEPTH = 16,
    parameter int                  ADDR_W     = 4,
    parameter int                  LEN_W      = 8,
    parameter int                  PRE_LEN    = 64,
    parameter logic [PRE_LEN-1:0]  PREAMBLE   = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter int                  SFD_LEN    = 16,
    parameter logic [SFD_LEN-1:0]  SFD        = 16'hF398,
    parameter int                  IFG        = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    frame_tx_lanes_if.slave  bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PRE_LANES  = PRE_LEN / LANE_W;
    localparam int SFD_LANES  = SFD_LEN / LANE_W;
    localparam int WORD_LANES = DATA_W / LANE_W;
    localparam int SH_W       = max2(max2(PRE_LEN, SFD_LEN), DATA_W);
    localparam int MAX_CNT    = max2(max2(PRE_LANES, SFD_LANES), max2(WORD_LANES, IFG));
    localparam int CNT_W      = $clog2(MAX_CNT + 1);
    localparam int LVL_W      = ADDR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_PAY, S_STALL, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              under_q, under_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              in_ready, wr_en, pop, fetch, load;

    assign in_ready = (level_q < LVL_W'(FIFO_DEPTH));
    assign wr_en    = bus.data_in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        sh_d    = sh_q >> LANE_W;
        valid_d = valid_q;
        under_d = 1'b0;
        fetch   = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sh_d    = '0;
                valid_d = 1'b0;
                if (bus.frame_en && (bus.frame_len != '0)) begin
                    state_d = S_PRE;
                    cnt_d   = CNT_W'(PRE_LANES - 1);
                    words_d = bus.frame_len - LEN_W'(1);
                    sh_d    = SH_W'(PREAMBLE);
                    valid_d = 1'b1;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_SFD;
                    cnt_d   = CNT_W'(SFD_LANES - 1);
                    sh_d    = SH_W'(SFD);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SFD: begin
                if (cnt_q == '0) fetch = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            S_PAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (words_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(IFG - 1);
                    sh_d    = '0;
                    valid_d = 1'b0;
                end else begin
                    words_d = words_q - LEN_W'(1);
                    fetch   = 1'b1;
                end
            end
            S_STALL: begin
                if (level_q != '0) load = 1'b1;
            end
            S_GAP: begin
                sh_d = '0;
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Fetch decisions look at the registered level, so a word written this cycle waits one cycle.
        if (fetch) begin
            if (level_q != '0) begin
                load = 1'b1;
            end else begin
                state_d = S_STALL;
                sh_d    = '0;
                valid_d = 1'b0;
                under_d = 1'b1;
            end
        end
        if (load) begin
            pop     = 1'b1;
            state_d = S_PAY;
            cnt_d   = CNT_W'(WORD_LANES - 1);
            sh_d    = SH_W'(mem[rd_ptr_q]);
            valid_d = 1'b1;
        end
        done_d = (state_d == S_PAY) && (cnt_d == '0) && (words_d == '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en)
            wr_ptr_d = (wr_ptr_q == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            words_q  <= '0;
            sh_q     <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            words_q  <= words_d;
            sh_q     <= sh_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            under_q  <= under_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign bus.data_out       = sh_q[LANE_W-1:0];
    assign bus.data_out_valid = valid_q;
    assign bus.frame_done     = done_q;
    assign bus.underrun       = under_q;
    assign bus.fifo_level     = level_q;
    assign bus.frame_ready    = (state_q == S_IDLE);
    assign bus.data_in_ready  = in_ready;
endmodule
